// File: rtl/sync_pixel_fifo_if.sv
// Write/read handshake and status bundle for sync_pixel_fifo.
// The master side drives the requests and the slave (FIFO) side returns data and flags.
interface sync_pixel_fifo_if #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 4
);
    logic                  clear;
    logic                  wren;
    logic [DATA_WIDTH-1:0] DataIn;
    logic                  rden;
    logic [DATA_WIDTH-1:0] DataOut;
    logic                  DataValid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   level;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output clear, wren, DataIn, rden,
        input  DataOut, DataValid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  clear, wren, DataIn, rden,
        output DataOut, DataValid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );
endinterface

// File: rtl/sync_pixel_fifo.sv
// Single-clock RGB444 pixel FIFO. Every entry is usable, and the depth is a power of two.
// The read path is either registered (1-cycle latency) or first-word-fall-through.
module sync_pixel_fifo #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_THRESH  = 12,
    parameter int AE_THRESH  = 2,
    parameter bit FWFT       = 1'b0
) (
    input logic              clk,
    input logic              rst,
    sync_pixel_fifo_if.slave fifo
);
    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wrptr, rdptr, lvl;
    logic                  full_w, empty_w, run, wr_ok, rd_ok;
    logic                  ovf_q, udf_q;

    // The extra wrap bit on each pointer tells a full FIFO apart from an empty one.
    assign lvl     = wrptr - rdptr;
    assign empty_w = (wrptr == rdptr);
    assign full_w  = (wrptr[ADDR_WIDTH] != rdptr[ADDR_WIDTH]) &&
                     (wrptr[ADDR_WIDTH-1:0] == rdptr[ADDR_WIDTH-1:0]);
    assign run     = !rst && !fifo.clear;
    assign wr_ok   = run && fifo.wren && !full_w;
    assign rd_ok   = run && fifo.rden && !empty_w;

    always_ff @(posedge clk) begin
        if (rst || fifo.clear) begin
            wrptr <= '0;
            rdptr <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wr_ok) wrptr <= wrptr + PW'(1);
            if (rd_ok) rdptr <= rdptr + PW'(1);
            if (fifo.wren && full_w)  ovf_q <= 1'b1;
            if (fifo.rden && empty_w) udf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wrptr[ADDR_WIDTH-1:0]] <= fifo.DataIn;
    end

    if (FWFT) begin : g_fwft
        assign fifo.DataOut   = mem[rdptr[ADDR_WIDTH-1:0]];
        assign fifo.DataValid = !empty_w;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_q;
        logic                  dv_q;
        // DataOut survives a flush and is only zeroed by reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                dout_q <= '0;
                dv_q   <= 1'b0;
            end else if (fifo.clear) begin
                dv_q   <= 1'b0;
            end else begin
                dv_q <= rd_ok;
                if (rd_ok) dout_q <= mem[rdptr[ADDR_WIDTH-1:0]];
            end
        end
        assign fifo.DataOut   = dout_q;
        assign fifo.DataValid = dv_q;
    end

    assign fifo.level        = lvl;
    assign fifo.full         = full_w;
    assign fifo.empty        = empty_w;
    assign fifo.almost_full  = (lvl >= PW'(AF_THRESH));
    assign fifo.almost_empty = (lvl <= PW'(AE_THRESH));
    assign fifo.overflow     = ovf_q;
    assign fifo.underflow    = udf_q;
endmodule

// File: tb/tb_sync_pixel_fifo.sv
// Bench for sync_pixel_fifo: a standard-read and an FWFT instance run in lockstep.
// Both are checked against a queue model, a vector table and corner-case sequences.
module tb_sync_pixel_fifo;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sync_pixel_fifo_if #(.DATA_WIDTH(12), .ADDR_WIDTH(4)) if_s ();
    sync_pixel_fifo_if #(.DATA_WIDTH(12), .ADDR_WIDTH(4)) if_f ();

    sync_pixel_fifo #(.DATA_WIDTH(12), .ADDR_WIDTH(4), .AF_THRESH(12), .AE_THRESH(2), .FWFT(1'b0))
        u_std (.clk(clk), .rst(rst), .fifo(if_s));
    sync_pixel_fifo #(.DATA_WIDTH(12), .ADDR_WIDTH(4), .AF_THRESH(12), .AE_THRESH(2), .FWFT(1'b1))
        u_fw  (.clk(clk), .rst(rst), .fifo(if_f));

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Behavioural reference
    logic [11:0] q[$];
    bit          m_ovf, m_udf, m_dv;
    logic [11:0] m_dout;

    typedef struct {
        bit          rst, clr, wr, rd;
        logic [11:0] din;
        int          lvl;
        bit          full, empty, af, ovf;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("level",        if_s.level, n);
        chk("full",         if_s.full, int'(n == DEPTH));
        chk("empty",        if_s.empty, int'(n == 0));
        chk("almost_full",  if_s.almost_full, int'(n >= 12));
        chk("almost_empty", if_s.almost_empty, int'(n <= 2));
        chk("overflow",     if_s.overflow, int'(m_ovf));
        chk("underflow",    if_s.underflow, int'(m_udf));
        chk("dvalid_std",   if_s.DataValid, int'(m_dv));
        chk("dout_std",     if_s.DataOut, int'(m_dout));
        chk("level_fwft",   if_f.level, n);
        chk("empty_fwft",   if_f.empty, int'(n == 0));
        chk("ovf_fwft",     if_f.overflow, int'(m_ovf));
        chk("udf_fwft",     if_f.underflow, int'(m_udf));
        chk("dvalid_fwft",  if_f.DataValid, int'(n > 0));
        if (n > 0) chk("dout_fwft", if_f.DataOut, int'(q[0]));
    endtask

    // One clock: drive at the falling edge, update the model at the rising edge, check at the next falling edge.
    task automatic step(input bit r, input bit c, input bit w, input bit rd, input logic [11:0] d);
        bit do_rd, do_wr;
        rst = r;
        if_s.clear = c; if_s.wren = w; if_s.rden = rd; if_s.DataIn = d;
        if_f.clear = c; if_f.wren = w; if_f.rden = rd; if_f.DataIn = d;
        @(posedge clk);
        cyc++;
        if (r) begin
            q.delete(); m_ovf = 0; m_udf = 0; m_dv = 0; m_dout = '0;
        end else if (c) begin
            q.delete(); m_ovf = 0; m_udf = 0; m_dv = 0;
        end else begin
            do_rd = rd && (q.size() > 0);
            do_wr = w && (q.size() < DEPTH);
            if (w && q.size() == DEPTH) m_ovf = 1;
            if (rd && q.size() == 0)    m_udf = 1;
            m_dv = do_rd;
            if (do_rd) m_dout = q.pop_front();
            if (do_wr) q.push_back(d);
        end
        @(negedge clk);
        check_all();
    endtask

    function automatic vec_t mk(bit r, bit w, logic [11:0] d, int l, bit f, bit e, bit af, bit ov);
        vec_t v;
        v.rst = r; v.clr = 0; v.wr = w; v.rd = 0; v.din = d;
        v.lvl = l; v.full = f; v.empty = e; v.af = af; v.ovf = ov;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] exp_o;
        rst = 1'b1;
        if_s.clear = 0; if_s.wren = 0; if_s.rden = 0; if_s.DataIn = '0;
        if_f.clear = 0; if_f.wren = 0; if_f.rden = 0; if_f.DataIn = '0;
        m_dout = '0;
        @(negedge clk);

        // Test 1: reset, fill to full, overflow on the 17th write
        tbl.push_back(mk(1, 0, 12'h000, 0, 0, 1, 0, 0));
        for (int i = 1; i <= 16; i++)
            tbl.push_back(mk(0, 1, 12'(i), i, i == 16, 0, i >= 12, 0));
        tbl.push_back(mk(0, 1, 12'hFFF, 16, 1, 0, 1, 1));
        foreach (tbl[k]) begin
            step(tbl[k].rst, tbl[k].clr, tbl[k].wr, tbl[k].rd, tbl[k].din);
            chk("tbl_level", if_s.level, tbl[k].lvl);
            chk("tbl_full",  if_s.full, int'(tbl[k].full));
            chk("tbl_empty", if_s.empty, int'(tbl[k].empty));
            chk("tbl_af",    if_s.almost_full, int'(tbl[k].af));
            chk("tbl_ovf",   if_s.overflow, int'(tbl[k].ovf));
        end

        // Test 2: standard-mode drain, then an underflow read
        for (int i = 1; i <= 16; i++) begin
            step(0, 0, 0, 1, '0);
            chk("drain_dout", if_s.DataOut, i);
            chk("drain_dv",   if_s.DataValid, 1);
        end
        chk("drain_empty", if_s.empty, 1);
        step(0, 0, 0, 1, '0);
        chk("udf_set",  if_s.underflow, 1);
        chk("udf_hold", if_s.DataOut, 12'h010);
        chk("udf_dv",   if_s.DataValid, 0);

        // Test 3: FWFT fall-through
        step(1, 0, 0, 0, '0);
        step(0, 0, 1, 0, 12'hABC);
        chk("fwft_dout",  if_f.DataOut, 12'hABC);
        chk("fwft_empty", if_f.empty, 0);
        step(0, 0, 0, 1, '0);
        chk("fwft_pop_empty", if_f.empty, 1);

        // Test 4: level 5 with concurrent read/write for 40 cycles
        step(1, 0, 0, 0, '0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 12'(12'h100 + i));
        for (int k = 0; k < 40; k++) begin
            step(0, 0, 1, 1, 12'(12'h200 + k));
            exp_o = (k < 5) ? 12'(12'h100 + k) : 12'(12'h200 + k - 5);
            chk("stream_level", if_s.level, 5);
            chk("stream_order", if_s.DataOut, exp_o);
        end

        // Test 5: simultaneous read/write at full and at empty
        step(1, 0, 0, 0, '0);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 12'(12'h300 + i));
        step(0, 0, 1, 1, 12'h777);
        chk("full_rw_level", if_s.level, 15);
        chk("full_rw_ovf",   if_s.overflow, 1);
        chk("full_rw_dout",  if_s.DataOut, 12'h300);
        step(1, 0, 0, 0, '0);
        step(0, 0, 1, 1, 12'h555);
        chk("empty_rw_level", if_s.level, 1);
        chk("empty_rw_udf",   if_s.underflow, 1);

        // Test 6: clear with wren high, then reset mid-burst
        step(0, 0, 0, 1, '0);
        step(0, 0, 0, 1, '0);
        for (int i = 0; i < 9; i++) step(0, 0, 1, 0, 12'(12'h400 + i));
        step(0, 1, 1, 0, 12'hEEE);
        chk("clr_level", if_s.level, 0);
        chk("clr_empty", if_s.empty, 1);
        chk("clr_udf",   if_s.underflow, 0);
        chk("clr_ovf",   if_s.overflow, 0);
        chk("clr_dout_hold", if_s.DataOut, 12'h555);
        for (int i = 0; i < 4; i++) step(0, 0, 1, i > 1, 12'(12'h600 + i));
        step(1, 0, 1, 1, 12'h6FF);
        chk("rst_level", if_s.level, 0);
        chk("rst_dout",  if_s.DataOut, 0);
        chk("rst_dv",    if_s.DataValid, 0);
        chk("rst_ae",    if_s.almost_empty, 1);

        // Random traffic with phases biased toward full and toward empty
        for (int k = 0; k < 3000; k++) begin
            int ph;
            bit w, r, c, x;
            ph = (k / 150) % 3;
            w  = ($urandom_range(99) < (ph == 0 ? 80 : ph == 1 ? 20 : 50));
            r  = ($urandom_range(99) < (ph == 0 ? 20 : ph == 1 ? 80 : 50));
            c  = ($urandom_range(199) == 0);
            x  = ($urandom_range(299) == 0);
            step(x, c, w, r, 12'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
